alu_issue_sched: RTL and testbench

- Shares the single 64-bit ALU between two requesters: req0 = integer issue and req1 = address/aux port.
- Arbitrates round-robin, latches the winning operation, and drives the ALU from registered operands.
- Models multi-cycle MUL-class and DIV-class timing with a countdown, then returns the result over a valid/ready response channel tagged with the requester id.
- Applies RISC-V divide-by-zero results in place of the ALU output.

---
 rtl/alu_issue_sched.sv | 186 ++++++++++++++++++
 tb/tb_alu_issue_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// Issue scheduler for the shared 64-bit ALU: round-robin grant between two ports,
// registered ALU operands, MUL/DIV latency countdown, and a tagged valid/ready response.
module alu_issue_sched #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [10:0] req0_opcode,
  input  logic [63:0] req0_value1,
  input  logic [63:0] req0_value2,
  input  logic [31:0] req0_imm,
  input  logic [5:0]  req0_shamt,
  input  logic [3:0]  req0_type,
  input  logic        req0_isW,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [10:0] req1_opcode,
  input  logic [63:0] req1_value1,
  input  logic [63:0] req1_value2,
  input  logic [31:0] req1_imm,
  input  logic [5:0]  req1_shamt,
  input  logic [3:0]  req1_type,
  input  logic        req1_isW,
  output logic [10:0] alu_opcode,
  output logic [63:0] alu_value1,
  output logic [63:0] alu_value2,
  output logic [31:0] alu_imm,
  output logic [5:0]  alu_shamt,
  output logic [3:0]  alu_type,
  output logic        alu_isW,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result
);

  // Opcode values shared with the ALU decode table
  localparam logic [10:0] OP_NOTHING = 11'h000;
  localparam logic [10:0] OP_MUL     = 11'h010;
  localparam logic [10:0] OP_MULH    = 11'h011;
  localparam logic [10:0] OP_MULHSU  = 11'h012;
  localparam logic [10:0] OP_MULHU   = 11'h013;
  localparam logic [10:0] OP_DIV     = 11'h014;
  localparam logic [10:0] OP_DIVU    = 11'h015;
  localparam logic [10:0] OP_REM     = 11'h016;
  localparam logic [10:0] OP_REMU    = 11'h017;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [3:0]  typ;
    logic        isw;
  } req_t;

  state_t        r_state, w_state_nxt;
  req_t          r_alu, w_alu_nxt;
  logic          r_last, w_last_nxt;
  logic          r_id, w_id_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_rsp_id, w_rsp_id_nxt;
  logic [63:0]   r_rsp_result, w_rsp_result_nxt;

  req_t          w_req0, w_req1, w_sel;
  logic          w_any, w_gnt, w_idle;
  logic [CW-1:0] w_lat_m1;
  logic          w_div_zero;
  logic [63:0]   w_final;

  assign w_req0 = {req0_opcode, req0_value1, req0_value2, req0_imm, req0_shamt, req0_type, req0_isW};
  assign w_req1 = {req1_opcode, req1_value1, req1_value2, req1_imm, req1_shamt, req1_type, req1_isW};

  // Contention goes to the port that did not win last; a lone request always wins
  assign w_any      = req0_valid | req1_valid;
  assign w_gnt      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_idle     = (r_state == IDLE);
  assign req0_ready = w_idle && w_any && !w_gnt;
  assign req1_ready = w_idle && w_any && w_gnt;
  assign w_sel      = w_gnt ? w_req1 : w_req0;

  always_comb begin
    w_lat_m1 = '0;
    if (w_sel.opcode inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
      w_lat_m1 = CW'(MUL_LAT - 1);
    else if (w_sel.opcode inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})
      w_lat_m1 = CW'(DIV_LAT - 1);
  end

  // RISC-V divide-by-zero results replace whatever the ALU produces
  assign w_div_zero = r_alu.isw ? (r_alu.v2[31:0] == 32'h0) : (r_alu.v2 == 64'h0);

  always_comb begin
    w_final = alu_result;
    if (r_alu.opcode == OP_NOTHING)
      w_final = '0;
    else if (w_div_zero && (r_alu.opcode inside {OP_DIV, OP_DIVU}))
      w_final = '1;
    else if (w_div_zero && (r_alu.opcode inside {OP_REM, OP_REMU}))
      w_final = r_alu.isw ? {{32{r_alu.v1[31]}}, r_alu.v1[31:0]} : r_alu.v1;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_alu_nxt        = r_alu;
    w_last_nxt       = r_last;
    w_id_nxt         = r_id;
    w_cnt_nxt        = r_cnt;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_id_nxt     = r_rsp_id;
    w_rsp_result_nxt = r_rsp_result;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_alu_nxt   = w_sel;
          w_last_nxt  = w_gnt;
          w_id_nxt    = w_gnt;
          w_cnt_nxt   = w_lat_m1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_rsp_result_nxt = w_final;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_id_nxt     = r_id;
          w_state_nxt      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_alu        <= '{opcode: OP_NOTHING, default: '0};
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_alu        <= w_alu_nxt;
      r_last       <= w_last_nxt;
      r_id         <= w_id_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_rsp_result <= w_rsp_result_nxt;
    end
  end

  assign alu_opcode = r_alu.opcode;
  assign alu_value1 = r_alu.v1;
  assign alu_value2 = r_alu.v2;
  assign alu_imm    = r_alu.imm;
  assign alu_shamt  = r_alu.shamt;
  assign alu_type   = r_alu.typ;
  assign alu_isW    = r_alu.isw;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: a behavioural ALU drives alu_result, and each scenario
// task compares DUT responses against results derived from RISC-V arithmetic rules.
module tb_alu_issue_sched;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  localparam logic [10:0] NOTHING = 11'h000, ADD = 11'h001, SUB = 11'h002, XOR = 11'h003;
  localparam logic [10:0] MUL = 11'h010, MULH = 11'h011, MULHSU = 11'h012, MULHU = 11'h013;
  localparam logic [10:0] DIV = 11'h014, DIVU = 11'h015, REM = 11'h016, REMU = 11'h017;
  localparam logic [3:0]  RTYPE = 4'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_isW;
  logic [10:0] req0_opcode;
  logic [63:0] req0_value1, req0_value2;
  logic [31:0] req0_imm;
  logic [5:0]  req0_shamt;
  logic [3:0]  req0_type;
  logic        req1_valid, req1_ready, req1_isW;
  logic [10:0] req1_opcode;
  logic [63:0] req1_value1, req1_value2;
  logic [31:0] req1_imm;
  logic [5:0]  req1_shamt;
  logic [3:0]  req1_type;
  logic [10:0] alu_opcode;
  logic [63:0] alu_value1, alu_value2, alu_result;
  logic [31:0] alu_imm;
  logic [5:0]  alu_shamt;
  logic [3:0]  alu_type;
  logic        alu_isW;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_value1(req0_value1), .req0_value2(req0_value2), .req0_imm(req0_imm),
    .req0_shamt(req0_shamt), .req0_type(req0_type), .req0_isW(req0_isW),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_value1(req1_value1), .req1_value2(req1_value2), .req1_imm(req1_imm),
    .req1_shamt(req1_shamt), .req1_type(req1_type), .req1_isW(req1_isW),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_imm(alu_imm), .alu_shamt(alu_shamt), .alu_type(alu_type), .alu_isW(alu_isW),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Plain ALU arithmetic; divide-by-zero and NOTHING return junk so the overrides are visible
  function automatic logic [63:0] arith(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                                        input logic w);
    logic [63:0]  r;
    logic [127:0] p;
    int           sa, sb;
    longint       la, lb;
    r  = 64'hDEAD_BEEF_0BAD_F00D;
    sa = a[31:0]; sb = b[31:0]; la = a; lb = b;
    case (op)
      ADD:   r = w ? sx(a[31:0] + b[31:0]) : a + b;
      SUB:   r = w ? sx(a[31:0] - b[31:0]) : a - b;
      XOR:   r = a ^ b;
      MUL:   r = w ? sx(a[31:0] * b[31:0]) : a * b;
      MULHU: begin p = {64'h0, a} * {64'h0, b}; r = p[127:64]; end
      DIV: if (w) begin
             if (sb != 0) r = (sa == 32'sh8000_0000 && sb == -1) ? sx(a[31:0]) : sx(32'(sa / sb));
           end else if (lb != 0) r = (la == 64'sh8000_0000_0000_0000 && lb == -1) ? a : 64'(la / lb);
      REM: if (w) begin
             if (sb != 0) r = (sb == -1) ? 64'h0 : sx(32'(sa % sb));
           end else if (lb != 0) r = (lb == -1) ? 64'h0 : 64'(la % lb);
      DIVU: if (w) begin if (b[31:0] != 0) r = sx(a[31:0] / b[31:0]); end
            else if (b != 0) r = a / b;
      REMU: if (w) begin if (b[31:0] != 0) r = sx(a[31:0] % b[31:0]); end
            else if (b != 0) r = a % b;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] expected(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                                           input logic w);
    logic zero;
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    if (op == NOTHING) return 64'h0;
    if (zero && (op == DIV || op == DIVU)) return '1;
    if (zero && (op == REM || op == REMU)) return w ? sx(a[31:0]) : a;
    return arith(op, a, b, w);
  endfunction

  function automatic int lat_of(input logic [10:0] op);
    if (op inside {MUL, MULH, MULHSU, MULHU}) return MUL_LAT;
    if (op inside {DIV, DIVU, REM, REMU}) return DIV_LAT;
    return 1;
  endfunction

  always_comb alu_result = arith(alu_opcode, alu_value1, alu_value2, alu_isW);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic w);
    if (idx == 0) begin
      req0_opcode = op; req0_value1 = a; req0_value2 = b; req0_imm = $urandom;
      req0_shamt = 6'($urandom); req0_type = RTYPE; req0_isW = w; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_value1 = a; req1_value2 = b; req1_imm = $urandom;
      req1_shamt = 6'($urandom); req1_type = RTYPE; req1_isW = w; req1_valid = 1'b1;
    end
  endtask

  task automatic clear_req();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  // Present one request, wait (bounded) for its grant, then wait for the response
  task automatic run_op(input int idx, input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic w, output int cyc);
    int n;
    set_req(idx, op, a, b, w);
    #1;
    n = 0;
    while (((idx == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    clear_req();
    wait_rsp(cyc);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    rsp_ready = 1'b1;
    clear_req();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_result !== 64'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if (alu_opcode !== NOTHING) begin errors++; $display("FAIL reset_alu_opcode got=%h exp=%h", alu_opcode, NOTHING); end
    checks++;
    if ({alu_value1, alu_value2, alu_imm, alu_shamt, alu_type, alu_isW} !== '0) begin
      errors++; $display("FAIL reset_alu_operands got=%h/%h/%h exp=0", alu_value1, alu_value2, alu_imm);
    end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_idle got=%b exp=00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_add();
    int cyc;
    set_req(0, ADD, 64'd5, 64'd7, 1'b0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_req0_ready got=%b exp=1", req0_ready); end
    step();
    clear_req();
    wait_rsp(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", cyc); end
    checks++; if (rsp_result !== 64'd12) begin errors++; $display("FAIL add_result got=%h exp=%h", rsp_result, 64'd12); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL add_id got=%b exp=0", rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop got=%b exp=0", rsp_valid); end
    checks++;
    if (alu_opcode !== ADD || alu_value1 !== 64'd5) begin
      errors++; $display("FAIL add_alu_hold got=%h/%h exp=%h/5", alu_opcode, alu_value1, ADD);
    end
  endtask

  task automatic test_arbitration();
    int          cyc;
    logic        exp_id;
    logic [63:0] exp_res;
    apply_reset();
    set_req(0, ADD, 64'd1, 64'd2, 1'b0);
    set_req(1, ADD, 64'd10, 64'd20, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 64'd30 : 64'd3;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL arb_grant_%0d got=%b exp=%b", k, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
      end
      step();
      wait_rsp(cyc);
      checks++;
      if (rsp_id !== exp_id || rsp_result !== exp_res) begin
        errors++; $display("FAIL arb_rsp_%0d got=%b/%h exp=%b/%h", k, rsp_id, rsp_result, exp_id, exp_res);
      end
      step();
    end
    clear_req();
  endtask

  task automatic test_muldiv();
    int cyc;
    run_op(0, MUL, 64'd3, -64'sd4, 1'b0, cyc);
    checks++; if (cyc != MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", cyc, MUL_LAT); end
    checks++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFF4) begin errors++; $display("FAIL mul_result got=%h exp=fffffffffffffff4", rsp_result); end
    step();
    run_op(1, DIV, 64'd100, 64'd7, 1'b0, cyc);
    checks++; if (cyc != DIV_LAT) begin errors++; $display("FAIL div_latency got=%0d exp=%0d", cyc, DIV_LAT); end
    checks++; if (rsp_result !== 64'd14 || rsp_id !== 1'b1) begin errors++; $display("FAIL div_result got=%h/%b exp=14/1", rsp_result, rsp_id); end
    step();
    run_op(0, REM, 64'd100, 64'd7, 1'b0, cyc);
    checks++; if (cyc != DIV_LAT || rsp_result !== 64'd2) begin errors++; $display("FAIL rem_result got=%h lat=%0d exp=2 lat=%0d", rsp_result, cyc, DIV_LAT); end
    step();
  endtask

  task automatic test_divzero();
    int cyc;
    run_op(0, DIV, 64'd77, 64'd0, 1'b0, cyc);
    checks++; if (cyc != DIV_LAT || rsp_result !== '1) begin errors++; $display("FAIL div0_result got=%h lat=%0d exp=all-ones", rsp_result, cyc); end
    step();
    run_op(1, REMU, 64'd9, 64'd0, 1'b0, cyc);
    checks++; if (rsp_result !== 64'd9) begin errors++; $display("FAIL remu0_result got=%h exp=9", rsp_result); end
    step();
    run_op(0, DIV, 64'd50, 64'h1_0000_0000, 1'b1, cyc);
    checks++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divw0_result got=%h exp=all-ones", rsp_result); end
    step();
    run_op(1, REM, 64'h0000_0001_8000_0005, 64'h2_0000_0000, 1'b1, cyc);
    checks++; if (rsp_result !== 64'hFFFF_FFFF_8000_0005) begin errors++; $display("FAIL remw0_result got=%h exp=ffffffff80000005", rsp_result); end
    step();
    run_op(0, NOTHING, 64'd4, 64'd4, 1'b0, cyc);
    checks++; if (cyc != 1 || rsp_result !== 64'h0) begin errors++; $display("FAIL nothing_result got=%h lat=%0d exp=0 lat=1", rsp_result, cyc); end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bad;
    run_op(1, ADD, 64'd40, 64'd2, 1'b0, cyc);
    rsp_ready = 1'b0;
    set_req(0, SUB, 64'd9, 64'd4, 1'b0);
    set_req(1, XOR, 64'hF0, 64'h0F, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 64'd42 || rsp_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got=%b/%h/%b rdy=%b exp=1/42/1 rdy=00", rsp_valid, rsp_result, rsp_id, {req1_ready, req0_ready}); end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_release_ready got=%b exp=00", {req1_ready, req0_ready}); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_bubble got=v%b rdy=%b exp=v0 rdy=01", rsp_valid, {req1_ready, req0_ready});
    end
    step();
    clear_req();
    wait_rsp(cyc);
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 64'd5) begin errors++; $display("FAIL bp_next got=%b/%h exp=0/5", rsp_id, rsp_result); end
    step();
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    bit seen;
    set_req(0, DIV, 64'd1000, 64'd3, 1'b0);
    #1;
    step();
    clear_req();
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0 || alu_opcode !== NOTHING) begin
      errors++; $display("FAIL midrst_state got=v%b op=%h exp=v0 op=%h", rsp_valid, alu_opcode, NOTHING);
    end
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_dropped got=rsp exp=none"); end
    set_req(0, ADD, 64'd8, 64'd8, 1'b0);
    set_req(1, ADD, 64'd1, 64'd1, 1'b0);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL midrst_grant got=%b exp=01", {req1_ready, req0_ready}); end
    step();
    clear_req();
    wait_rsp(cyc);
    checks++; if (rsp_result !== 64'd16 || rsp_id !== 1'b0) begin errors++; $display("FAIL midrst_first got=%h/%b exp=16/0", rsp_result, rsp_id); end
    step();
  endtask

  task automatic test_random();
    logic [10:0] ops[10] = '{NOTHING, ADD, SUB, XOR, MUL, MULHU, DIV, DIVU, REM, REMU};
    logic [10:0] op[2];
    logic [63:0] a[2], b[2];
    logic        w[2];
    logic        last, win;
    int          pat, cyc, bp;
    logic [63:0] exp_res;
    apply_reset();
    last = 1'b1;
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(0, 2);
      for (int r = 0; r < 2; r++) begin
        op[r] = ops[$urandom_range(0, 9)];
        a[r]  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       b[r] = 64'h0;
          1:       b[r] = 64'($urandom_range(1, 20));
          2:       b[r] = {32'($urandom), 32'h0};
          default: b[r] = {$urandom, $urandom};
        endcase
        w[r] = 1'($urandom_range(0, 1));
        if (pat == 2 || pat == r) set_req(r, op[r], a[r], b[r], w[r]);
      end
      win  = (pat == 2) ? ~last : (pat == 1);
      last = win;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rnd_grant_%0d got=%b exp=%b", it, {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
      end
      step();
      clear_req();
      exp_res = expected(op[win], a[win], b[win], w[win]);
      wait_rsp(cyc);
      checks++; if (cyc != lat_of(op[win])) begin errors++; $display("FAIL rnd_latency_%0d op=%h got=%0d exp=%0d", it, op[win], cyc, lat_of(op[win])); end
      bp = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      repeat (bp) step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_id !== win) begin
        errors++; $display("FAIL rnd_rsp_%0d op=%h got=%b/%h/%b exp=1/%h/%b", it, op[win], rsp_valid, rsp_result, rsp_id, exp_res, win);
      end
      rsp_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b1;
    clear_req();
    set_req(0, NOTHING, '0, '0, 1'b0);
    set_req(1, NOTHING, '0, '0, 1'b0);
    clear_req();
    test_reset();
    test_add();
    test_arbitration();
    test_muldiv();
    test_divzero();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
